// File: rtl/i2_vector_loader.sv
// i2 input stage: packs a narrow word stream into the 201-bit pi vector
// and holds the finished frame in a handshaked output register.
module i2_vector_loader #(
  parameter int VEC_W  = 201,
  parameter int WORD_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              vec_valid,
  input  logic              vec_ready,
  output logic [VEC_W-1:0]  vec_data,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int NBEATS    = (VEC_W + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = VEC_W - (NBEATS - 1) * WORD_W;
  localparam int ASM_W     = (NBEATS - 1) * WORD_W;
  localparam int BW        = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LASTB = BW'(NBEATS - 1);

  typedef enum logic {
    FILL,
    DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [ASM_W-1:0]   asm_q, asm_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic               vld_q, vld_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0]   ecnt_q, ecnt_d;
  logic               at_last;
  logic               acc;
  logic               done;
  logic               bad;

  // Only the final beat waits on a full output register.
  assign at_last  = (state_q == FILL) && (beat_q == LASTB);
  assign in_ready = rst_n && !(at_last && vld_q && !vec_ready);
  assign acc      = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    asm_d   = asm_q;
    vec_d   = vec_q;
    vld_d   = vld_q;
    err_d   = 1'b0;
    fcnt_d  = fcnt_q;
    ecnt_d  = ecnt_q;
    done    = 1'b0;
    bad     = 1'b0;
    if (vld_q && vec_ready) begin
      vld_d = 1'b0;
    end
    if (acc) begin
      unique case (state_q)
        FILL: begin
          if (!at_last) begin
            if (in_last) begin
              bad    = 1'b1;
              beat_d = '0;
            end else begin
              for (int b = 0; b < NBEATS - 1; b++) begin
                if (beat_q == BW'(b)) begin
                  asm_d[b*WORD_W +: WORD_W] = in_data;
                end
              end
              beat_d = beat_q + BW'(1);
            end
          end else if (in_last) begin
            done   = 1'b1;
            beat_d = '0;
            vec_d  = {in_data[LAST_BITS-1:0], asm_q};
          end else begin
            bad     = 1'b1;
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (in_last) begin
            state_d = FILL;
            beat_d  = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end
    if (done) begin
      vld_d = 1'b1;
      if (fcnt_q != '1) fcnt_d = fcnt_q + CNT_W'(1);
    end
    if (bad) begin
      err_d = 1'b1;
      if (ecnt_q != '1) ecnt_d = ecnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      beat_q  <= '0;
      asm_q   <= '0;
      vec_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      asm_q   <= asm_d;
      vec_q   <= vec_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign vec_valid = vld_q;
  assign vec_data  = vec_q;
  assign frame_err = err_q;
  assign frame_cnt = fcnt_q;
  assign err_cnt   = ecnt_q;

endmodule

// File: tb/tb_i2_vector_loader.sv
// Directed bench for i2_vector_loader: framing, back-pressure,
// error recovery, mid-frame reset and final-word masking.
module tb_i2_vector_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         vec_valid;
  logic         vec_ready;
  logic [200:0] vec_data;
  logic         frame_err;
  logic [15:0]  frame_cnt;
  logic [15:0]  err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]   fw [26];
  logic [200:0] exp1, exp2, expv;

  always #5 clk = ~clk;

  i2_vector_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .vec_valid(vec_valid),
    .vec_ready(vec_ready),
    .vec_data (vec_data),
    .frame_err(frame_err),
    .frame_cnt(frame_cnt),
    .err_cnt  (err_cnt)
  );

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [200:0] pack();
    logic [200:0] v;
    v = '0;
    for (int b = 0; b < 25; b++) v[b*8 +: 8] = fw[b];
    v[200] = fw[25][0];
    return v;
  endfunction

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int nb, input logic last_end);
    for (int b = 0; b < nb; b++) begin
      send(fw[b], last_end && (b == nb - 1));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    vec_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_vec_valid", vec_valid, 0);
    check("rst_vec_data", vec_data, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_frame_err", frame_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: all-ones frame
    vec_ready = 1'b1;
    for (int b = 0; b < 25; b++) fw[b] = 8'hFF;
    fw[25] = 8'h01;
    exp1 = {201{1'b1}};
    send_frame(25, 1'b0);
    check("t1_not_yet_valid", vec_valid, 0);
    send(fw[25], 1'b1);
    vec_ready = 1'b0;
    check("t1_valid", vec_valid, 1);
    check("t1_data", vec_data, exp1);
    check("t1_frame_cnt", frame_cnt, 1);

    // T2: back-pressure on the final beat
    for (int b = 0; b < 26; b++) fw[b] = b[0] ? 8'h5A : 8'hA5;
    exp2 = pack();
    send_frame(25, 1'b0);
    in_valid = 1'b1;
    in_data  = fw[25];
    in_last  = 1'b1;
    #1;
    check("t2_stall", in_ready, 0);
    @(posedge clk);
    #1;
    check("t2_still_stall", in_ready, 0);
    check("t2_hold_valid", vec_valid, 1);
    check("t2_hold_data", vec_data, exp1);
    vec_ready = 1'b1;
    #1;
    check("t2_release", in_ready, 1);
    @(posedge clk);
    #1;
    vec_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    check("t2_valid", vec_valid, 1);
    check("t2_data", vec_data, exp2);
    check("t2_frame_cnt", frame_cnt, 2);

    // T3: early last on beat 10, then a clean frame
    vec_ready = 1'b1;
    for (int b = 0; b < 26; b++) fw[b] = 8'(b * 3 + 1);
    send_frame(11, 1'b1);
    check("t3_err_pulse", frame_err, 1);
    check("t3_err_cnt", err_cnt, 1);
    check("t3_no_valid", vec_valid, 0);
    @(posedge clk);
    #1;
    check("t3_err_low", frame_err, 0);
    expv = pack();
    send_frame(26, 1'b1);
    check("t3_valid", vec_valid, 1);
    check("t3_data", vec_data, expv);
    check("t3_frame_cnt", frame_cnt, 3);

    // T4: missing last, drain three words, then a clean frame
    for (int b = 0; b < 26; b++) fw[b] = 8'(8'hC0 ^ b);
    send_frame(26, 1'b0);
    check("t4_err_pulse", frame_err, 1);
    check("t4_err_cnt", err_cnt, 2);
    send(8'h11, 1'b0);
    check("t4_err_once", frame_err, 0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    check("t4_drain_no_err", err_cnt, 2);
    check("t4_drain_no_valid", vec_valid, 0);
    expv = pack();
    send_frame(26, 1'b1);
    check("t4_valid", vec_valid, 1);
    check("t4_data", vec_data, expv);
    check("t4_frame_cnt", frame_cnt, 4);

    // T5: reset at beat 12
    for (int b = 0; b < 26; b++) fw[b] = 8'h77;
    send_frame(12, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("t5_vec_valid", vec_valid, 0);
    check("t5_vec_data", vec_data, 0);
    check("t5_frame_cnt", frame_cnt, 0);
    check("t5_err_cnt", err_cnt, 0);
    for (int b = 0; b < 26; b++) fw[b] = 8'(8'h40 + b);
    expv = pack();
    send_frame(26, 1'b1);
    check("t5_valid", vec_valid, 1);
    check("t5_data", vec_data, expv);
    check("t5_beat0", vec_data[7:0], 8'h40);
    check("t5_frame_cnt", frame_cnt, 1);

    // T6: only bit 0 of the final word lands
    for (int b = 0; b < 25; b++) fw[b] = 8'h96;
    fw[25] = 8'hFE;
    expv = pack();
    send_frame(26, 1'b1);
    check("t6_fe_bit200", vec_data[200], 0);
    check("t6_fe_data", vec_data, expv);
    fw[25] = 8'h01;
    expv = pack();
    send_frame(26, 1'b1);
    check("t6_01_bit200", vec_data[200], 1);
    check("t6_01_data", vec_data, expv);
    fw[25] = 8'hFF;
    send_frame(26, 1'b1);
    check("t6_ff_data", vec_data, expv);
    check("t6_frame_cnt", frame_cnt, 4);
    check("t6_err_cnt", err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
